pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Consumer of the hazard unit's stall/branch/jump decisions. Turns hazard,
//  redirect, cache-hit and halt events into per-latch enable/flush strobes for
//  the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sits beside the hazard
//  unit in the 5-stage pipeline datapath. Owns the halt-drain state machine.
// PARAMETERS
//  CNT_W         32  width of performance counters
//  DRAIN_STAGES  3   pipeline advances after HALT leaves ID before HALTED
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      synchronous reset, active-high
//  ihit         in   1      icache hit for current PC
//  dhit         in   1      dcache hit for MEM-stage access
//  id_hazard    in   1      hazard unit: stall ID (operands not ready)
//  id_branch    in   1      hazard unit: taken BEQ/BNE in ID
//  id_jump      in   1      hazard unit: J/JAL/JR in ID
//  id_halt      in   1      HALT opcode decoded in ID
//  mem_dmemREN  in   1      MEM-stage load
//  mem_dmemWEN  in   1      MEM-stage store
//  pc_en        out  1      PC register load enable
//  pc_redirect  out  1      PC mux selects branch/jump target
//  ifid_en      out  1      IF/ID enable;  ifid_flush  out 1  IF/ID clear to NOP
//  idex_en      out  1      ID/EX enable;  idex_flush  out 1  ID/EX clear to NOP
//  exmem_en     out  1      EX/MEM enable; exmem_flush out 1  EX/MEM clear to NOP
//  memwb_en     out  1      MEM/WB enable
//  imemREN      out  1      instruction fetch request
//  halt         out  1      sticky; pipeline drained, caches may flush
//  perf_cycles/perf_stalls/perf_redirects  out  CNT_W  (PERF_CNT_EN only)
// BEHAVIOUR
//  - RST high (sampled at edge): state=RUN, drain_cnt=0, counters=0. Outputs are
//    decoded from registered state; in cycle after reset: halt=0, rest per RUN.
//  - dstall = (mem_dmemREN|mem_dmemWEN) & !dhit. dstall freezes every latch and
//    PC: all *_en=0, all *_flush=0. Highest priority in RUN and DRAIN.
//  - RUN, !dstall, priority id_hazard > (id_branch|id_jump) > !ihit:
//    * id_hazard: pc_en=0, ifid_en=0, idex_flush=1, exmem/memwb advance;
//      redirect suppressed this cycle (re-evaluated next cycle).
//    * redirect: pc_en=1, pc_redirect=1, ifid_flush=1 (independent of ihit).
//    * !ihit: pc_en=0, ifid_flush=1 (bubble), downstream advance.
//    * else: all enables 1, flushes 0.
//  - id_halt in RUN with !dstall & !id_hazard: HALT enters ID/EX, state->DRAIN,
//    drain_cnt=1. Halt overrides redirect in same cycle.
//  - DRAIN: pc_en=0, imemREN=0, ifid_flush=1, idex_flush=1; EX/MEM, MEM/WB
//    advance when !dstall; drain_cnt++ per advance; at drain_cnt==DRAIN_STAGES
//    with advance -> HALTED.
//  - HALTED: halt=1, all *_en=0, flushes 0, terminal until RST.
//  - imemREN=1 in RUN only. Simultaneous dhit & redirect: redirect honoured
//    same cycle. drain_cnt width clog2(DRAIN_STAGES+1).
// CONFIGURATION
//  PIPELINE_CTRL_PERF_CNT_EN defined: perf_cycles counts every non-HALTED cycle;
//  perf_stalls counts cycles with pc_en=0 in RUN; perf_redirects counts
//  pc_redirect=1 cycles; all saturate at 2^CNT_W-1, freeze in HALTED.
//  Undefined: perf ports absent, no counter flops.
// STRUCTURE
//  cpu_types_pkg: pipe_ctrl_state_t enum {RUN, DRAIN, HALTED}.
//  Sub-module pipe_perf_counters (saturating counters), instantiated only
//  under PIPELINE_CTRL_PERF_CNT_EN. Control decode stays inline.
// TESTING
//  1 RST 2 cycles, ihit=1, no events -> all en=1, flush=0, halt=0, state RUN.
//  2 mem_dmemREN=1, dhit=0 for 5 cycles -> all en=0 5 cycles; dhit=1 -> resume.
//  3 id_hazard=1 & id_branch=1 -> pc_en=0, idex_flush=1, pc_redirect=0;
//    next cycle hazard=0 -> pc_redirect=1, ifid_flush=1.
//  4 ihit=0 & id_jump=1 -> pc_en=1, pc_redirect=1, ifid_flush=1.
//  5 id_halt=1, dstall 2 cycles mid-drain -> HALTED after exactly 3 advances
//    (5 cycles); halt stays 1 for 10 more cycles.
//  6 PERF_CNT_EN, CNT_W=4: 20 stall cycles -> perf_stalls holds 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: halt-drain state encoding, latch strobe bundle, perf counter indices.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic imem_ren;
    logic halt;
  } pipe_strobe_t;

  localparam int NUM_PERF  = 3;
  localparam int PERF_CYC  = 0;
  localparam int PERF_STL  = 1;
  localparam int PERF_RDR  = 2;

endpackage

// File: rtl/pipeline_ctrl_perf_counters.sv
// Saturating performance counters; one pipe_sat_cnt instance per event line.
module pipe_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge CLK) begin
    if (RST)                   cnt <= '0;
    else if (inc && ~&cnt)     cnt <= cnt + 1'b1;
  end
endmodule

module pipe_perf_counters #(
  parameter int CNT_W = 32,
  parameter int NUM   = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM-1:0]            inc,
  output logic [NUM-1:0][CNT_W-1:0] cnt
);
  for (genvar g = 0; g < NUM; g++) begin : g_cnt
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (inc[g]),
      .cnt (cnt[g])
    );
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch enable/flush control and halt-drain FSM for the 5-stage core.
// Optional perf counters under `PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_STAGES = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic ihit,
  input  logic dhit,
  input  logic id_hazard,
  input  logic id_branch,
  input  logic id_jump,
  input  logic id_halt,
  input  logic mem_dmemREN,
  input  logic mem_dmemWEN,
  output logic pc_en,
  output logic pc_redirect,
  output logic ifid_en,
  output logic ifid_flush,
  output logic idex_en,
  output logic idex_flush,
  output logic exmem_en,
  output logic exmem_flush,
  output logic memwb_en,
  output logic imemREN,
  output logic halt
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_stalls,
  output logic [CNT_W-1:0] perf_redirects
`endif
);

  localparam int DCNT_W = $clog2(DRAIN_STAGES + 1);

  pipe_ctrl_state_t  state;
  logic [DCNT_W-1:0] drain_cnt;
  logic              dstall;
  logic              redirect;
  pipe_strobe_t      s;

  assign dstall   = (mem_dmemREN | mem_dmemWEN) & ~dhit;
  assign redirect = id_branch | id_jump;

  always_comb begin
    s = '0;
    case (state)
      RUN: begin
        s.imem_ren = 1'b1;
        if (dstall) begin
          // memory stall freezes everything, fetch request held
        end else if (id_hazard) begin
          s.idex_en    = 1'b1;
          s.idex_flush = 1'b1;
          s.exmem_en   = 1'b1;
          s.memwb_en   = 1'b1;
        end else if (id_halt) begin
          // HALT moves into ID/EX; younger fetch squashed, PC frozen
          s.ifid_en    = 1'b1;
          s.ifid_flush = 1'b1;
          s.idex_en    = 1'b1;
          s.exmem_en   = 1'b1;
          s.memwb_en   = 1'b1;
        end else if (redirect) begin
          s.pc_en       = 1'b1;
          s.pc_redirect = 1'b1;
          s.ifid_en     = 1'b1;
          s.ifid_flush  = 1'b1;
          s.idex_en     = 1'b1;
          s.exmem_en    = 1'b1;
          s.memwb_en    = 1'b1;
        end else if (!ihit) begin
          s.ifid_en    = 1'b1;
          s.ifid_flush = 1'b1;
          s.idex_en    = 1'b1;
          s.exmem_en   = 1'b1;
          s.memwb_en   = 1'b1;
        end else begin
          s.pc_en    = 1'b1;
          s.ifid_en  = 1'b1;
          s.idex_en  = 1'b1;
          s.exmem_en = 1'b1;
          s.memwb_en = 1'b1;
        end
      end
      DRAIN: begin
        if (!dstall) begin
          s.ifid_en    = 1'b1;
          s.ifid_flush = 1'b1;
          s.idex_en    = 1'b1;
          s.idex_flush = 1'b1;
          s.exmem_en   = 1'b1;
          s.memwb_en   = 1'b1;
        end
      end
      HALTED: s.halt = 1'b1;
      default: ;
    endcase
  end

  assign pc_en       = s.pc_en;
  assign pc_redirect = s.pc_redirect;
  assign ifid_en     = s.ifid_en;
  assign ifid_flush  = s.ifid_flush;
  assign idex_en     = s.idex_en;
  assign idex_flush  = s.idex_flush;
  assign exmem_en    = s.exmem_en;
  assign exmem_flush = s.exmem_flush;
  assign memwb_en    = s.memwb_en;
  assign imemREN     = s.imem_ren;
  assign halt        = s.halt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: if (!dstall && !id_hazard && id_halt) begin
          state     <= DRAIN;
          drain_cnt <= DCNT_W'(1);
        end
        DRAIN: if (!dstall) begin
          if (drain_cnt == DCNT_W'(DRAIN_STAGES)) state <= HALTED;
          else                                    drain_cnt <= drain_cnt + 1'b1;
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [NUM_PERF-1:0]            perf_inc;
  logic [NUM_PERF-1:0][CNT_W-1:0] perf_cnt;

  always_comb begin
    perf_inc           = '0;
    perf_inc[PERF_CYC] = (state != HALTED);
    perf_inc[PERF_STL] = (state == RUN) & ~s.pc_en;
    perf_inc[PERF_RDR] = s.pc_redirect;
  end

  pipe_perf_counters #(.CNT_W(CNT_W), .NUM(NUM_PERF)) u_perf (
    .CLK (CLK),
    .RST (RST),
    .inc (perf_inc),
    .cnt (perf_cnt)
  );

  assign perf_cycles    = perf_cnt[PERF_CYC];
  assign perf_stalls    = perf_cnt[PERF_STL];
  assign perf_redirects = perf_cnt[PERF_RDR];
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected strobes, negedge monitor compares.
module tb_pipeline_ctrl;
  localparam int CNT_W = 4;

  // {pc_en,pc_redirect,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,exmem_flush,memwb_en,imemREN,halt}
  localparam logic [10:0] E_RUN    = 11'b10101010110;
  localparam logic [10:0] E_DSTRUN = 11'b00000000010;
  localparam logic [10:0] E_HAZ    = 11'b00001110110;
  localparam logic [10:0] E_REDIR  = 11'b11111010110;
  localparam logic [10:0] E_MISS   = 11'b00111010110;
  localparam logic [10:0] E_HENTRY = 11'b00111010110;
  localparam logic [10:0] E_DRAIN  = 11'b00111110100;
  localparam logic [10:0] E_DRSTL  = 11'b00000000000;
  localparam logic [10:0] E_HALTED = 11'b00000000001;

  // {hazard,branch,jump,halt,ihit,dhit,ren,wen}
  localparam logic [7:0] I_IDLE = 8'b00001100;
  localparam logic [7:0] I_DST  = 8'b00001010;

  logic CLK = 1'b0, RST = 1'b1;
  logic ihit = 1'b1, dhit = 1'b1, id_hazard = 1'b0, id_branch = 1'b0;
  logic id_jump = 1'b0, id_halt = 1'b0, mem_dmemREN = 1'b0, mem_dmemWEN = 1'b0;
  logic pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, imemREN, halt;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] perf_cycles, perf_stalls, perf_redirects;
`endif

  pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_STAGES(3)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_hazard(id_hazard),
    .id_branch(id_branch), .id_jump(id_jump), .id_halt(id_halt),
    .mem_dmemREN(mem_dmemREN), .mem_dmemWEN(mem_dmemWEN),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .imemREN(imemREN), .halt(halt)
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_redirects(perf_redirects)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] exp;
    string       nm;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  wire [10:0] act = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, exmem_flush, memwb_en, imemREN, halt};

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.exp);
      end
    end
  end

  task automatic step(input logic [7:0] in, input logic [10:0] exp, input string nm);
    sb_t e;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    {id_hazard, id_branch, id_jump, id_halt, ihit, dhit, mem_dmemREN, mem_dmemWEN} = in;
    e.exp = exp;
    e.nm  = nm;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(posedge CLK);
      #1;
      RST = 1'b1;
      {id_hazard, id_branch, id_jump, id_halt, ihit, dhit, mem_dmemREN, mem_dmemWEN} = I_IDLE;
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    do_reset();
    step(I_IDLE, E_RUN, "reset_idle0");
    step(I_IDLE, E_RUN, "reset_idle1");

    repeat (5) step(I_DST, E_DSTRUN, "dstall_load");
    step(8'b00001110, E_RUN, "dstall_resume");
    step(8'b00001001, E_DSTRUN, "dstall_store");

    step(8'b11001100, E_HAZ,   "hazard_over_branch");
    step(8'b01001100, E_REDIR, "branch_after_hazard");
    step(8'b00100100, E_REDIR, "jump_on_imiss");
    step(8'b00000100, E_MISS,  "imiss_bubble");
    step(8'b01001110, E_REDIR, "dhit_with_branch");
    step(8'b11001010, E_DSTRUN, "dstall_over_hazard");
    step(8'b10011100, E_HAZ,   "hazard_blocks_halt");
    step(I_IDLE, E_RUN, "still_run_after_blocked_halt");

    step(8'b01011100, E_HENTRY, "halt_over_branch");
    step(I_IDLE, E_DRAIN, "drain_adv1");
    step(I_DST,  E_DRSTL, "drain_stall1");
    step(I_DST,  E_DRSTL, "drain_stall2");
    step(I_IDLE, E_DRAIN, "drain_adv2");
    step(8'b01001100, E_DRAIN, "drain_adv3");
    for (int i = 0; i < 10; i++)
      step((i % 2) ? I_DST : 8'b01101100, E_HALTED, "halted_sticky");

    do_reset();
    step(I_IDLE, E_RUN, "reset_from_halted");

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    do_reset();
    repeat (20) step(I_DST, E_DSTRUN, "perf_stall_cycle");
    @(negedge CLK);
    chk_val("perf_stalls_sat", 32'(perf_stalls), 32'd15);
    chk_val("perf_cycles_sat", 32'(perf_cycles), 32'd15);
    chk_val("perf_redirects_zero", 32'(perf_redirects), 32'd0);
    do_reset();
    repeat (3) step(8'b01001100, E_REDIR, "perf_redirect_cycle");
    step(I_IDLE, E_RUN, "perf_idle");
    @(negedge CLK);
    chk_val("perf_redirects_cnt", 32'(perf_redirects), 32'd3);
    chk_val("perf_stalls_none", 32'(perf_stalls), 32'd0);
`endif

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 required", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
